uart_rx_framer: RTL and testbench

8N1 UART receiver for the 25 MHz-derived uart_rx_clk domain; it produces the byte stream that is written into the UART-to-Ethernet FIFO.
- Resynchronises the asynchronous serial line and finds start bits.
- Majority-votes each bit at mid-period, checks the stop bit.
- Emits a one-cycle write strobe per good byte.
- Drops a byte, and counts the drop, when the downstream FIFO reports full.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx_framer.sv | 113 +++++++++++
 tb/tb_uart_rx_framer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_rx_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Two-of-three majority used for the mid-bit vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Resynchronises the raw serial line, flags a 1->0 transition and provides
// a three-sample majority over the current and two previous synced samples.
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic fall,
  output logic vote
);

  logic s1;
  logic d1;
  logic d2;

  // Two-flop synchroniser plus a two-deep history; all reset to idle-high so
  // releasing reset can never look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
      d1   <= 1'b1;
      d2   <= 1'b1;
    end else begin
      s1   <= rx_in;
      rx_s <= s1;
      d1   <= rx_s;
      d2   <= d1;
    end
  end

  assign fall = d1 & ~rx_s;
  assign vote = maj3(rx_s, d1, d2);

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: start detection, mid-bit majority sampling, stop check,
// single-cycle write strobe and a saturating count of bytes lost to a full FIFO.
//
// Handshake: rx_done_signal is a one-cycle valid with rx_data valid in the same
// cycle; there is no ready. fifo_full acts as a not-ready sampled at the
// stop-bit vote point -- when high the byte is dropped and counted instead.
module uart_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MID          = CLKS_PER_BIT / 2,
  parameter int DROP_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic                      rx_enable_signal,
  input  logic                      fifo_full,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_done_signal,
  output logic                      frame_err,
  output logic                      busy,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // The window covers MID-1..MID+1, so the vote is complete at MID+1.
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(MID + 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_e                 state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_next;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_s;
  logic                      fall;
  logic                      vote;
  logic                      start_edge;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx_in(rx_in),
    .rx_s (rx_s),
    .fall (fall),
    .vote (vote)
  );

  // fall already implies rx_s low; the explicit term keeps the qualifier
  // readable as "enabled, line now low, and it was high last cycle".
  assign start_edge = rx_enable_signal & fall & ~rx_s;
  assign cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  assign busy       = (state != IDLE);

  // Receive FSM with bit counter, data shift register and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      rx_data        <= '0;
      rx_done_signal <= 1'b0;
      frame_err      <= 1'b0;
      drop_count     <= '0;
    end else begin
      rx_done_signal <= 1'b0;
      frame_err      <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (start_edge) state <= START;
        end
        START: begin
          cnt <= cnt_next;
          if (cnt == CNT_VOTE && vote) begin
            state <= IDLE;   // line went back high: glitch, not a start bit
          end else if (cnt == CNT_LAST) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          cnt <= cnt_next;
          if (cnt == CNT_VOTE) shreg <= {vote, shreg[UART_DATA_BITS-1:1]};
          if (cnt == CNT_LAST) begin
            if (bit_idx == LAST_BIT) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          cnt <= cnt_next;
          // Leave at mid-stop-bit so the next start edge is never missed.
          if (cnt == CNT_VOTE) begin
            state <= IDLE;
            if (vote) begin
              rx_data <= shreg;
              if (!fifo_full)               rx_done_signal <= 1'b1;
              else if (drop_count != '1)    drop_count     <= drop_count + 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 16 clocks per bit.
module tb_uart_rx_framer;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_in = 1'b1;
  logic        rx_enable_signal = 1'b1;
  logic        fifo_full = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_done_signal;
  logic        frame_err;
  logic        busy;
  logic [15:0] drop_count;
  logic [7:0]  rx_data2;
  logic        rx_done2;
  logic        frame_err2;
  logic        busy2;
  logic [1:0]  drop_count2;

  int total = 0;
  int bad   = 0;

  // monitor state (written only by the monitor)
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         dbl = 0;
  int         busy_cycles = 0;
  int         low_run = 0;
  int         last_gap = 0;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] got_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_in           (rx_in),
    .rx_enable_signal(rx_enable_signal),
    .fifo_full       (fifo_full),
    .rx_data         (rx_data),
    .rx_done_signal  (rx_done_signal),
    .frame_err       (frame_err),
    .busy            (busy),
    .drop_count      (drop_count)
  );

  // narrow drop counter instance to reach saturation quickly
  uart_rx_framer #(.CLKS_PER_BIT(CPB), .DROP_W(2)) dut2 (
    .clk             (clk),
    .rst             (rst),
    .rx_in           (rx_in),
    .rx_enable_signal(rx_enable_signal),
    .fifo_full       (fifo_full),
    .rx_data         (rx_data2),
    .rx_done_signal  (rx_done2),
    .frame_err       (frame_err2),
    .busy            (busy2),
    .drop_count      (drop_count2)
  );

  // monitor: strobe capture, pulse-shape tracking, busy-low gap length
  always @(negedge clk) begin
    if (rx_done_signal) begin
      done_cnt = done_cnt + 1;
      got_q.push_back(rx_data);
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (rx_done_signal && frame_err) dbl = dbl + 1;
    if ((rx_done_signal || frame_err) && (prev_done || prev_err)) dbl = dbl + 1;
    prev_done = rx_done_signal;
    prev_err  = frame_err;
    if (busy) begin
      busy_cycles = busy_cycles + 1;
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run = low_run + 1;
    end
  end

  // driver: start bit, 8 data bits LSB first, stop bit; optional one-cycle
  // spike inside a data bit and optional enable drop at the start of a bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit,
                            input int spike_off, input int en_off_bit);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b == en_off_bit && c == 0) rx_enable_signal = 1'b0;
        rx_in = (b == spike_bit + 1 && c == spike_off) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    total++; if ({rx_done_signal, frame_err, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {rx_done_signal, frame_err, busy}); end
    total++; if (drop_count !== 16'h0000) begin bad++; $display("FAIL reset_drop got=%h exp=0000", drop_count); end
    rst = 1'b0;
    idle(10);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int base = done_cnt;
    int ebase = err_cnt;
    int dbase = dbl;
    send_frame(8'h55, 1'b1, -5, 0, -1);
    send_frame(8'hA3, 1'b1, -5, 0, -1);
    idle(20);
    total++; if (done_cnt - base !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", done_cnt - base); end
    if (got_q.size() >= 2) begin
      total++; if (got_q[got_q.size()-2] !== 8'h55) begin bad++; $display("FAIL b2b_first got=%h exp=55", got_q[got_q.size()-2]); end
      total++; if (got_q[got_q.size()-1] !== 8'hA3) begin bad++; $display("FAIL b2b_second got=%h exp=a3", got_q[got_q.size()-1]); end
    end
    total++; if (err_cnt - ebase !== 0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - ebase); end
    total++; if (dbl - dbase !== 0) begin bad++; $display("FAIL b2b_pulse_shape got=%0d exp=0", dbl - dbase); end
    total++; if (last_gap < 1 || last_gap > 15) begin bad++; $display("FAIL b2b_gap got=%0d exp=1..15", last_gap); end
  endtask

  task automatic test_false_start();
    int base = done_cnt;
    int ebase = err_cnt;
    int bbase = busy_cycles;
    // 3-cycle glitch, then a start bit that returns high at cnt=4
    for (int g = 0; g < 2; g++) begin
      int k;
      rx_in = 1'b0;
      repeat (g == 0 ? 3 : 5) @(negedge clk);
      rx_in = 1'b1;
      for (k = 0; k < 12; k++) begin
        if (!busy) break;
        @(negedge clk);
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL false_start_busy%0d got=%b exp=0", g, busy); end
      idle(30);
    end
    total++; if (busy_cycles - bbase < 2) begin bad++; $display("FAIL false_start_seen got=%0d exp>=2", busy_cycles - bbase); end
    total++; if (done_cnt - base !== 0) begin bad++; $display("FAIL false_start_done got=%0d exp=0", done_cnt - base); end
    total++; if (err_cnt - ebase !== 0) begin bad++; $display("FAIL false_start_err got=%0d exp=0", err_cnt - ebase); end
  endtask

  task automatic test_frame_err();
    int base = done_cnt;
    int ebase = err_cnt;
    int dbase = dbl;
    send_frame(8'h3C, 1'b0, -5, 0, -1);
    idle(20);
    total++; if (err_cnt - ebase !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", err_cnt - ebase); end
    total++; if (done_cnt - base !== 0) begin bad++; $display("FAIL ferr_done got=%0d exp=0", done_cnt - base); end
    total++; if (rx_data !== 8'hA3) begin bad++; $display("FAIL ferr_rx_data got=%h exp=a3", rx_data); end
    total++; if (dbl - dbase !== 0) begin bad++; $display("FAIL ferr_pulse_shape got=%0d exp=0", dbl - dbase); end
  endtask

  task automatic test_spike();
    int base = done_cnt;
    send_frame(8'h00, 1'b1, 2, 9, -1);
    idle(20);
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL spike_count got=%0d exp=1", done_cnt - base); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[got_q.size()-1] !== 8'h00) begin bad++; $display("FAIL spike_data got=%h exp=00", got_q[got_q.size()-1]); end
    end
  endtask

  task automatic test_fifo_full();
    int base = done_cnt;
    fifo_full = 1'b1;
    send_frame(8'h12, 1'b1, -5, 0, -1);
    idle(20);
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL drop_one got=%0d exp=1", drop_count); end
    total++; if (rx_data !== 8'h12) begin bad++; $display("FAIL drop_rx_data got=%h exp=12", rx_data); end
    total++; if (drop_count2 !== 2'd1) begin bad++; $display("FAIL drop2_one got=%0d exp=1", drop_count2); end
    send_frame(8'h34, 1'b1, -5, 0, -1);
    send_frame(8'h56, 1'b1, -5, 0, -1);
    idle(20);
    total++; if (drop_count2 !== 2'd3) begin bad++; $display("FAIL drop2_full got=%0d exp=3", drop_count2); end
    send_frame(8'h78, 1'b1, -5, 0, -1);
    idle(20);
    total++; if (drop_count !== 16'd4) begin bad++; $display("FAIL drop_four got=%0d exp=4", drop_count); end
    total++; if (drop_count2 !== 2'd3) begin bad++; $display("FAIL drop2_saturate got=%0d exp=3", drop_count2); end
    total++; if (done_cnt - base !== 0) begin bad++; $display("FAIL drop_done got=%0d exp=0", done_cnt - base); end
    fifo_full = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base = done_cnt;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;                    // data bits of 0xFF
    repeat (4 * CPB + 8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({rx_data, rx_done_signal, frame_err, busy} !== 11'h000) begin bad++; $display("FAIL midrst_outputs got=%h exp=000", {rx_data, rx_done_signal, frame_err, busy}); end
    total++; if (drop_count !== 16'h0000) begin bad++; $display("FAIL midrst_drop got=%h exp=0000", drop_count); end
    rst = 1'b0;
    idle(150);
    total++; if (done_cnt - base !== 0) begin bad++; $display("FAIL midrst_no_strobe got=%0d exp=0", done_cnt - base); end
    send_frame(8'hC3, 1'b1, -5, 0, -1);
    idle(20);
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL midrst_next_count got=%0d exp=1", done_cnt - base); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[got_q.size()-1] !== 8'hC3) begin bad++; $display("FAIL midrst_next_data got=%h exp=c3", got_q[got_q.size()-1]); end
    end
  endtask

  task automatic test_enable_drop();
    int base = done_cnt;
    int bbase;
    send_frame(8'h5A, 1'b1, -5, 0, 2);
    idle(20);
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL en_complete_count got=%0d exp=1", done_cnt - base); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[got_q.size()-1] !== 8'h5A) begin bad++; $display("FAIL en_complete_data got=%h exp=5a", got_q[got_q.size()-1]); end
    end
    bbase = busy_cycles;
    send_frame(8'h81, 1'b1, -5, 0, -1);
    idle(20);
    total++; if (busy_cycles - bbase !== 0) begin bad++; $display("FAIL en_ignored_busy got=%0d exp=0", busy_cycles - bbase); end
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL en_ignored_done got=%0d exp=1", done_cnt - base); end
    rx_enable_signal = 1'b1;
    idle(5);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_spike();
    test_fifo_full();
    test_reset_mid();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
